wb_reg_file: RTL and testbench

- Write-back end of the MEM/WB pipeline interface. Consumes the registered WB-stage write stream (GPR write plus HI/LO write).
- Holds the architectural state: 32 x 32-bit GPRs and the HI/LO pair.
- Serves two combinational GPR read ports to ID and a HI/LO read to EX.
- Sits between the MEM/WB pipeline register outputs and the ID/EX operand logic.

---
 rtl/wb_reg_file_pkg.sv | 20 ++
 rtl/wb_reg_file_if.sv | 35 +++
 rtl/wb_reg_file_hilo_reg.sv | 43 ++++
 rtl/wb_reg_file.sv | 63 ++++++
 tb/tb_wb_reg_file.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/wb_reg_file_pkg.sv
// Shared widths, types and helpers for the write-back register file.
// The GPR count is derived from the address width, so the two always agree.
package wb_reg_file_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 5;
   localparam int REG_NUM    = 1 << ADDR_WIDTH;

   typedef logic [DATA_WIDTH-1:0] data_t;
   typedef logic [ADDR_WIDTH-1:0] addr_t;

   localparam data_t ZERO_WORD = '0;
   localparam addr_t REG_ZERO  = '0;

   // Address 0 is $zero: never stored, always reads back as zero.
   function automatic logic is_zero_addr(input addr_t addr);
      return addr == REG_ZERO;
   endfunction

endpackage

// File: rtl/wb_reg_file_if.sv
// MEM/WB write stream plus the ID/EX read ports of the register file.
// The master is the pipeline side; the slave is wb_reg_file.
interface wb_reg_file_if;
   import wb_reg_file_pkg::*;

   logic  write_reg_en;
   addr_t write_reg_addr;
   data_t write_reg_data;
   logic  write_hilo_en;
   data_t write_hi_data;
   data_t write_lo_data;
   logic  read1_en;
   addr_t read1_addr;
   data_t read1_data;
   logic  read2_en;
   addr_t read2_addr;
   data_t read2_data;
   data_t hi_data;
   data_t lo_data;

   modport master (
      output write_reg_en, write_reg_addr, write_reg_data,
      output write_hilo_en, write_hi_data, write_lo_data,
      output read1_en, read1_addr, read2_en, read2_addr,
      input  read1_data, read2_data, hi_data, lo_data
   );

   modport slave (
      input  write_reg_en, write_reg_addr, write_reg_data,
      input  write_hilo_en, write_hi_data, write_lo_data,
      input  read1_en, read1_addr, read2_en, read2_addr,
      output read1_data, read2_data, hi_data, lo_data
   );

endinterface

// File: rtl/wb_reg_file_hilo_reg.sv
// HI/LO register pair with a joint write strobe and async active-low clear.
// Defining REGFILE_BYPASS_EN makes a same-cycle write visible on the outputs.
module hilo_reg
   import wb_reg_file_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  we,
   input  data_t hi_in,
   input  data_t lo_in,
   output data_t hi_out,
   output data_t lo_out
);

   data_t hi_q;
   data_t lo_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hi_q <= ZERO_WORD;
         lo_q <= ZERO_WORD;
      end else if (we) begin
         hi_q <= hi_in;
         lo_q <= lo_in;
      end
   end

   // Reset forces zero on the outputs even while a bypassed write is pending.
   always_comb begin
      hi_out = ZERO_WORD;
      lo_out = ZERO_WORD;
      if (rst) begin
`ifdef REGFILE_BYPASS_EN
         hi_out = we ? hi_in : hi_q;
         lo_out = we ? lo_in : lo_q;
`else
         hi_out = hi_q;
         lo_out = lo_q;
`endif
      end
   end

endmodule

// File: rtl/wb_reg_file.sv
// Architectural GPR file and HI/LO pair fed by the MEM/WB write stream.
// Defining REGFILE_BYPASS_EN enables write-first bypass on both read ports and HI/LO.
module wb_reg_file
   import wb_reg_file_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   wb_reg_file_if.slave bus
);

   data_t gpr [REG_NUM];
   data_t read1_val;
   data_t read2_val;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < REG_NUM; i++) begin
            gpr[i] <= ZERO_WORD;
         end
      end else if (bus.write_reg_en && !is_zero_addr(bus.write_reg_addr)) begin
         gpr[bus.write_reg_addr] <= bus.write_reg_data;
      end
   end

   // Disabled ports, $zero and reset all read as zero; bypass only applies to real registers.
   always_comb begin
      read1_val = ZERO_WORD;
      if (rst && bus.read1_en && !is_zero_addr(bus.read1_addr)) begin
         read1_val = gpr[bus.read1_addr];
`ifdef REGFILE_BYPASS_EN
         if (bus.write_reg_en && bus.write_reg_addr == bus.read1_addr) begin
            read1_val = bus.write_reg_data;
         end
`endif
      end
   end

   always_comb begin
      read2_val = ZERO_WORD;
      if (rst && bus.read2_en && !is_zero_addr(bus.read2_addr)) begin
         read2_val = gpr[bus.read2_addr];
`ifdef REGFILE_BYPASS_EN
         if (bus.write_reg_en && bus.write_reg_addr == bus.read2_addr) begin
            read2_val = bus.write_reg_data;
         end
`endif
      end
   end

   assign bus.read1_data = read1_val;
   assign bus.read2_data = read2_val;

   hilo_reg u_hilo_reg (
      .clk    (clk),
      .rst    (rst),
      .we     (bus.write_hilo_en),
      .hi_in  (bus.write_hi_data),
      .lo_in  (bus.write_lo_data),
      .hi_out (bus.hi_data),
      .lo_out (bus.lo_data)
   );

endmodule

// File: tb/tb_wb_reg_file.sv
// Scoreboard bench for wb_reg_file: directed plan steps followed by random traffic,
// with expectations from an array-based model of the architectural state.
module tb_wb_reg_file;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   typedef struct {
      string       name;
      logic        rst;
      logic        wen;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        hen;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        r1en;
      logic [4:0]  r1a;
      logic        r2en;
      logic [4:0]  r2a;
   } stim_t;

   typedef struct {
      string       name;
      logic [31:0] r1;
      logic [31:0] r2;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   wb_reg_file_if bus ();

   wb_reg_file dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   exp_t        sb_q [$];
   logic [31:0] model_gpr [32];
   logic [31:0] model_hi;
   logic [31:0] model_lo;
   int          checkCount = 0;
   int          passCount  = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   function automatic logic [31:0] expRead(input stim_t s, input logic en, input logic [4:0] a);
      if (!s.rst || !en || a == 5'd0) return 32'h0;
      if (BYPASS && s.wen && s.waddr == a) return s.wdata;
      return model_gpr[a];
   endfunction

   function automatic stim_t idle(input string name);
      stim_t s;
      s.name = name;
      s.rst = 1'b1;
      s.wen = 1'b0;  s.waddr = 5'd0; s.wdata = 32'h0;
      s.hen = 1'b0;  s.hi = 32'h0;   s.lo = 32'h0;
      s.r1en = 1'b0; s.r1a = 5'd0;
      s.r2en = 1'b0; s.r2a = 5'd0;
      return s;
   endfunction

   // Drive one cycle of inputs just after a rising edge, queue the expected
   // outputs for the monitor, then fold this cycle's writes into the model.
   task automatic applyStimulus(input stim_t s);
      exp_t e;
      @(posedge clk);
      #1;
      rst                = s.rst;
      bus.write_reg_en   = s.wen;
      bus.write_reg_addr = s.waddr;
      bus.write_reg_data = s.wdata;
      bus.write_hilo_en  = s.hen;
      bus.write_hi_data  = s.hi;
      bus.write_lo_data  = s.lo;
      bus.read1_en       = s.r1en;
      bus.read1_addr     = s.r1a;
      bus.read2_en       = s.r2en;
      bus.read2_addr     = s.r2a;
      if (!s.rst) begin
         foreach (model_gpr[i]) model_gpr[i] = 32'h0;
         model_hi = 32'h0;
         model_lo = 32'h0;
      end
      e.name = s.name;
      e.r1 = expRead(s, s.r1en, s.r1a);
      e.r2 = expRead(s, s.r2en, s.r2a);
      e.hi = !s.rst ? 32'h0 : (BYPASS && s.hen) ? s.hi : model_hi;
      e.lo = !s.rst ? 32'h0 : (BYPASS && s.hen) ? s.lo : model_lo;
      sb_q.push_back(e);
      if (s.rst) begin
         if (s.wen && s.waddr != 5'd0) model_gpr[s.waddr] = s.wdata;
         if (s.hen) begin
            model_hi = s.hi;
            model_lo = s.lo;
         end
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checkOutput({e.name, ".read1"}, bus.read1_data, e.r1);
            checkOutput({e.name, ".read2"}, bus.read2_data, e.r2);
            checkOutput({e.name, ".hi"}, bus.hi_data, e.hi);
            checkOutput({e.name, ".lo"}, bus.lo_data, e.lo);
         end
      end
   end

   initial begin
      stim_t s;
      int    waitCycles;
      foreach (model_gpr[i]) model_gpr[i] = 32'h0;
      model_hi = 32'h0;
      model_lo = 32'h0;
      s = idle("init");
      bus.write_reg_en = 1'b0; bus.write_reg_addr = '0; bus.write_reg_data = '0;
      bus.write_hilo_en = 1'b0; bus.write_hi_data = '0; bus.write_lo_data = '0;
      bus.read1_en = 1'b0; bus.read1_addr = '0; bus.read2_en = 1'b0; bus.read2_addr = '0;

      s = idle("reset_state"); s.rst = 1'b0; s.wen = 1'b1; s.waddr = 5'd4; s.wdata = 32'hCAFE;
      s.hen = 1'b1; s.hi = 32'h77; s.r1en = 1'b1; s.r1a = 5'd4; s.r2en = 1'b1; s.r2a = 5'd9;
      applyStimulus(s);
      s = idle("release_with_write"); s.wen = 1'b1; s.waddr = 5'd5; s.wdata = 32'h1234;
      s.hen = 1'b1; s.hi = 32'hA5A5A5A5; s.lo = 32'h5A5A5A5A; s.r1en = 1'b1; s.r1a = 5'd4;
      applyStimulus(s);
      s = idle("gpr5_before_reset"); s.r1en = 1'b1; s.r1a = 5'd5; applyStimulus(s);
      s = idle("reset_midcycle"); s.rst = 1'b0; s.r1en = 1'b1; s.r1a = 5'd5;
      s.r2en = 1'b1; s.r2a = 5'd5; applyStimulus(s);

      s = idle("write_gpr7"); s.wen = 1'b1; s.waddr = 5'd7; s.wdata = 32'hDEADBEEF; applyStimulus(s);
      s = idle("read_gpr7_both"); s.r1en = 1'b1; s.r1a = 5'd7; s.r2en = 1'b1; s.r2a = 5'd7; applyStimulus(s);
      s = idle("read2_disabled"); s.r1en = 1'b1; s.r1a = 5'd7; s.r2a = 5'd7; applyStimulus(s);

      s = idle("write_zero"); s.wen = 1'b1; s.waddr = 5'd0; s.wdata = 32'hFFFFFFFF;
      s.r1en = 1'b1; s.r1a = 5'd0; applyStimulus(s);
      s = idle("read_zero"); s.r1en = 1'b1; s.r1a = 5'd0; s.r2en = 1'b1; s.r2a = 5'd7; applyStimulus(s);

      s = idle("hazard_gpr3"); s.wen = 1'b1; s.waddr = 5'd3; s.wdata = 32'h55;
      s.r1en = 1'b1; s.r1a = 5'd3; s.r2en = 1'b1; s.r2a = 5'd3; applyStimulus(s);
      s = idle("after_gpr3"); s.r1en = 1'b1; s.r1a = 5'd3; applyStimulus(s);

      s = idle("hilo_and_gpr9"); s.hen = 1'b1; s.hi = 32'h1; s.lo = 32'h2;
      s.wen = 1'b1; s.waddr = 5'd9; s.wdata = 32'h9; applyStimulus(s);
      s = idle("hilo_hold"); s.hi = $urandom; s.lo = $urandom; s.r1en = 1'b1; s.r1a = 5'd9; applyStimulus(s);
      s = idle("x_on_disabled"); s.wdata = 'x; s.waddr = 5'd9; s.hi = 'x; s.lo = 'x;
      s.r1en = 1'b1; s.r1a = 5'd9; applyStimulus(s);
      s = idle("x_check"); s.r1en = 1'b1; s.r1a = 5'd9; s.r2en = 1'b1; s.r2a = 5'd3; applyStimulus(s);

      s = idle("gpr31_first"); s.wen = 1'b1; s.waddr = 5'd31; s.wdata = 32'h10;
      s.r1en = 1'b1; s.r1a = 5'd31; applyStimulus(s);
      s = idle("gpr31_second"); s.wen = 1'b1; s.waddr = 5'd31; s.wdata = 32'h20;
      s.r1en = 1'b1; s.r1a = 5'd31; applyStimulus(s);
      s = idle("gpr31_final"); s.r1en = 1'b1; s.r1a = 5'd31; applyStimulus(s);

      for (int n = 0; n < 400; n++) begin
         s = idle("random");
         s.rst   = ($urandom_range(0, 59) != 0);
         s.wen   = ($urandom_range(0, 3) != 0);
         s.waddr = 5'($urandom_range(0, 31));
         s.wdata = $urandom;
         s.hen   = ($urandom_range(0, 2) == 0);
         s.hi    = $urandom;
         s.lo    = $urandom;
         s.r1en  = ($urandom_range(0, 4) != 0);
         s.r1a   = ($urandom_range(0, 2) == 0) ? s.waddr : 5'($urandom_range(0, 31));
         s.r2en  = ($urandom_range(0, 4) != 0);
         s.r2a   = ($urandom_range(0, 3) == 0) ? s.r1a : 5'($urandom_range(0, 31));
         applyStimulus(s);
      end

      waitCycles = 0;
      while (sb_q.size() > 0 && waitCycles < 10) begin
         @(posedge clk);
         waitCycles++;
      end
      if (sb_q.size() > 0) begin
         checkCount++;
         $display("[TB] FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
      end
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
